ahb2apb_arbiter: RTL and testbench

- Two-master AHB-Lite arbiter that shares the single AHB-to-APB bridge in the peripheral subsystem between master 0 (core data port) and master 1 (debug/DMA).
- Each master's address phase is captured into a pending slot. Pending transfers are issued to the bridge one at a time with round-robin priority.
- Data phases are forwarded back to the owning master.
- A watchdog converts a hung bridge transfer into an AHB ERROR response.

---
 rtl/ahb2apb_arbiter.sv | 131 +++++++++++++
 tb/tb_ahb2apb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_arbiter.sv
// ahb2apb_arbiter: shares one AHB-to-APB bridge between two AHB-Lite masters with round-robin grant and a hang watchdog
module ahb2apb_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        m0_hsel,
  input  logic        m0_hready,
  input  logic [1:0]  m0_htrans,
  input  logic [31:0] m0_haddr,
  input  logic [31:0] m0_hwdata,
  input  logic        m0_hwrite,
  output logic        m0_hreadyout,
  output logic [31:0] m0_hrdata,
  output logic [1:0]  m0_hresp,
  input  logic        m1_hsel,
  input  logic        m1_hready,
  input  logic [1:0]  m1_htrans,
  input  logic [31:0] m1_haddr,
  input  logic [31:0] m1_hwdata,
  input  logic        m1_hwrite,
  output logic        m1_hreadyout,
  output logic [31:0] m1_hrdata,
  output logic [1:0]  m1_hresp,
  output logic        s_hsel,
  output logic        s_hready,
  output logic        s_hwrite,
  output logic [1:0]  s_htrans,
  output logic [31:0] s_haddr,
  output logic [31:0] s_hwdata,
  input  logic        s_hreadyout,
  input  logic [31:0] s_hrdata,
  input  logic [1:0]  s_hresp
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR1, ERR2} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic pend0_q, pend0_d, pend1_q, pend1_d;
  logic rr_q, rr_d, gnt_q, gnt_d;
  logic wr0_q, wr1_q;
  logic [31:0] addr0_q, addr1_q;
  logic [15:0] cnt_q, cnt_d;
  logic cap0, cap1, done0, done1, resp_ok, resp_err;
  logic unused_htrans;
  assign unused_htrans = m0_htrans[0] ^ m1_htrans[0];
  assign cap0 = m0_hsel & m0_htrans[1] & m0_hready;
  assign cap1 = m1_hsel & m1_htrans[1] & m1_hready;
  assign resp_ok = (state_q == DATA) & s_hreadyout;
  assign resp_err = (state_q == ERR1) | (state_q == ERR2);
  assign done0 = ~gnt_q & (resp_ok | (state_q == ERR2));
  assign done1 = gnt_q & (resp_ok | (state_q == ERR2));
  assign pend0_d = cap0 | (pend0_q & ~done0);
  assign pend1_d = cap1 | (pend1_q & ~done1);
  assign m0_hreadyout = ~pend0_q | done0;
  assign m1_hreadyout = ~pend1_q | done1;
  assign m0_hrdata = (resp_ok & ~gnt_q) ? s_hrdata : '0;
  assign m1_hrdata = (resp_ok & gnt_q) ? s_hrdata : '0;
  assign m0_hresp = (resp_ok & ~gnt_q) ? s_hresp : (resp_err & ~gnt_q) ? 2'b01 : 2'b00;
  assign m1_hresp = (resp_ok & gnt_q) ? s_hresp : (resp_err & gnt_q) ? 2'b01 : 2'b00;
  // state, pending slots, captured address phases, priority pointer and watchdog
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= IDLE;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      rr_q <= 1'b0;
      gnt_q <= 1'b0;
      cnt_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      wr0_q <= 1'b0;
      wr1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      if (cap0) begin
        addr0_q <= m0_haddr;
        wr0_q <= m0_hwrite;
      end
      if (cap1) begin
        addr1_q <= m1_haddr;
        wr1_q <= m1_hwrite;
      end
    end
  end
  // grant selection, bridge-side signalling and watchdog for the one transfer in flight
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    s_hsel = 1'b0;
    s_htrans = 2'b00;
    s_haddr = '0;
    s_hwrite = 1'b0;
    s_hready = 1'b1;
    s_hwdata = '0;
    case (state_q)
      IDLE: if (pend0_q | pend1_q) begin
        gnt_d = (pend0_q & pend1_q) ? rr_q : pend1_q;
        state_d = ADDR;
      end
      ADDR: begin
        s_hsel = 1'b1;
        s_htrans = 2'b10;
        s_haddr = gnt_q ? addr1_q : addr0_q;
        s_hwrite = gnt_q ? wr1_q : wr0_q;
        cnt_d = '0;
        state_d = DATA;
      end
      DATA: begin
        s_hwdata = gnt_q ? m1_hwdata : m0_hwdata;
        if (s_hreadyout) begin
          rr_d = ~gnt_q;
          state_d = IDLE;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) state_d = ERR1;
        else cnt_d = cnt_q + 16'd1;
      end
      ERR1: state_d = ERR2;
      ERR2: begin
        rr_d = ~rr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ahb2apb_arbiter.sv
// tb_ahb2apb_arbiter: directed and random stimulus checked against a transaction-level reference of the arbiter
module tb_ahb2apb_arbiter;
  localparam int TO = 8;
  localparam int S_A = 0, S_D = 1, S_E1 = 2, S_E2 = 3;
  logic HCLK = 1'b0, HRESETN = 1'b1;
  logic m0_hsel = 1'b0, m1_hsel = 1'b0, m0_hwrite = 1'b0, m1_hwrite = 1'b0;
  logic [1:0] m0_htrans = 2'b00, m1_htrans = 2'b00;
  logic [31:0] m0_haddr = '0, m1_haddr = '0, m0_hwdata = '0, m1_hwdata = '0;
  logic m0_hready, m1_hready, m0_hreadyout, m1_hreadyout;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [1:0] m0_hresp, m1_hresp;
  logic s_hsel, s_hready, s_hwrite;
  logic [1:0] s_htrans;
  logic [31:0] s_haddr, s_hwdata;
  logic s_hreadyout = 1'b1;
  logic [31:0] s_hrdata = '0;
  logic [1:0] s_hresp = 2'b00;
  int errors = 0, checks = 0;
  logic [1:0] mp, cmp, erdy;
  logic [31:0] ma [2];
  logic mw [2];
  int rr, own, stage, wt;
  int sel_cnt = 0, low0 = 0, low1 = 0, n0, l0;
  logic [31:0] got [2];
  logic [31:0] last_addr = '0;
  logic [2:0] last_m0 = '0;
  logic [35:0] last_s = '0;
  logic gq [$];

  assign m0_hready = m0_hreadyout;
  assign m1_hready = m1_hreadyout;

  ahb2apb_arbiter #(.TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .m0_hsel(m0_hsel), .m0_hready(m0_hready), .m0_htrans(m0_htrans), .m0_haddr(m0_haddr),
    .m0_hwdata(m0_hwdata), .m0_hwrite(m0_hwrite), .m0_hreadyout(m0_hreadyout),
    .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
    .m1_hsel(m1_hsel), .m1_hready(m1_hready), .m1_htrans(m1_htrans), .m1_haddr(m1_haddr),
    .m1_hwdata(m1_hwdata), .m1_hwrite(m1_hwrite), .m1_hreadyout(m1_hreadyout),
    .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
    .s_hsel(s_hsel), .s_hready(s_hready), .s_hwrite(s_hwrite), .s_htrans(s_htrans),
    .s_haddr(s_haddr), .s_hwdata(s_hwdata), .s_hreadyout(s_hreadyout),
    .s_hrdata(s_hrdata), .s_hresp(s_hresp)
  );

  always #5 HCLK = ~HCLK;

  task automatic mreset();
    mp = 2'b00;
    cmp = 2'b00;
    erdy = 2'b11;
    rr = 0;
    own = -1;
    stage = S_A;
    wt = 0;
    for (int n = 0; n < 2; n++) begin
      ma[n] = '0;
      mw[n] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check();
    logic [1:0] xr [2];
    logic [31:0] xd [2];
    logic sel, fin;
    int o;
    o = own < 0 ? 0 : own;
    sel = own >= 0 && stage == S_A;
    fin = own >= 0 && stage == S_D && s_hreadyout;
    for (int n = 0; n < 2; n++) begin
      cmp[n] = own == n && (fin || stage == S_E2);
      erdy[n] = !mp[n] || cmp[n];
      xr[n] = (own == n && fin) ? s_hresp : (own == n && stage >= S_E1) ? 2'b01 : 2'b00;
      xd[n] = (own == n && fin) ? s_hrdata : 32'h0;
    end
    chk("m0_ready_resp", 64'({m0_hreadyout, m0_hresp}), 64'({erdy[0], xr[0]}));
    chk("m0_hrdata", 64'(m0_hrdata), 64'(xd[0]));
    chk("m1_ready_resp", 64'({m1_hreadyout, m1_hresp}), 64'({erdy[1], xr[1]}));
    chk("m1_hrdata", 64'(m1_hrdata), 64'(xd[1]));
    chk("bridge_addr_phase", 64'({s_hsel, s_htrans, s_hwrite, s_hready, s_haddr}),
        64'({sel, sel, 1'b0, sel & mw[o], 1'b1, sel ? ma[o] : 32'h0}));
    if (own >= 0 && stage == S_D) chk("s_hwdata", 64'(s_hwdata), 64'(own == 1 ? m1_hwdata : m0_hwdata));
    if (fin) got[o] = o == 1 ? m1_hrdata : m0_hrdata;
    if (s_hsel) begin
      sel_cnt++;
      last_addr = s_haddr;
      gq.push_back(s_haddr[28]);
    end
    if (!m0_hreadyout) low0++;
    if (!m1_hreadyout) low1++;
    last_m0 = {m0_hreadyout, m0_hresp};
    last_s = {s_hsel, s_htrans, s_hwrite, s_haddr};
  endtask

  task automatic update();
    logic [1:0] old, cap;
    if (!HRESETN) mreset();
    else begin
      cap = {m1_hsel & m1_htrans[1] & erdy[1], m0_hsel & m0_htrans[1] & erdy[0]};
      old = mp;
      mp = cap | (mp & ~cmp);
      if (cap[0]) begin
        ma[0] = m0_haddr;
        mw[0] = m0_hwrite;
      end
      if (cap[1]) begin
        ma[1] = m1_haddr;
        mw[1] = m1_hwrite;
      end
      if (own < 0) begin
        if (old != 2'b00) begin
          own = (old == 2'b11) ? rr : (old[1] ? 1 : 0);
          stage = S_A;
        end
      end else if (stage == S_A) begin
        stage = S_D;
        wt = 0;
      end else if (stage == S_D) begin
        if (s_hreadyout) begin
          rr = 1 - own;
          own = -1;
        end else begin
          wt++;
          if (TO != 0 && wt == TO) stage = S_E1;
        end
      end else if (stage == S_E1) stage = S_E2;
      else begin
        rr = 1 - rr;
        own = -1;
      end
    end
  endtask

  task automatic step();
    #1 check();
    @(posedge HCLK);
    update();
    #1;
  endtask

  task automatic drv(input int n, input logic s, input logic [1:0] t, input logic [31:0] a, input logic w);
    if (n == 0) begin
      m0_hsel = s;
      m0_htrans = t;
      m0_haddr = a;
      m0_hwrite = w;
    end else begin
      m1_hsel = s;
      m1_htrans = t;
      m1_haddr = a;
      m1_hwrite = w;
    end
  endtask

  task automatic br(input logic r, input logic [31:0] d, input logic [1:0] p);
    s_hreadyout = r;
    s_hrdata = d;
    s_hresp = p;
  endtask

  initial begin
    #1 HRESETN = 1'b0;
    mreset();
    step();
    chk("reset_m0", 64'(last_m0), 64'(3'b100));
    chk("reset_bridge", 64'(last_s), 64'(0));
    step();
    HRESETN = 1'b1;
    // M0 single write, bridge ready on its second data cycle
    n0 = sel_cnt;
    br(1'b0, 32'h0, 2'b00);
    drv(0, 1'b1, 2'b10, 32'h4000_0010, 1'b1);
    step();
    drv(0, 1'b0, 2'b00, 32'h0, 1'b0);
    m0_hwdata = 32'hDEAD_BEEF;
    step();
    step();
    chk("t1_addr", 64'(last_addr), 64'(32'h4000_0010));
    step();
    br(1'b1, 32'h0, 2'b00);
    step();
    chk("t1_m0_okay", 64'(last_m0), 64'(3'b100));
    chk("t1_pulses", 64'(sel_cnt - n0), 64'(1));
    // both masters read in the same cycle right after reset
    HRESETN = 1'b0;
    mreset();
    step();
    HRESETN = 1'b1;
    got[0] = '0;
    got[1] = '0;
    br(1'b1, 32'h11, 2'b00);
    drv(0, 1'b1, 2'b10, 32'h4000_0100, 1'b0);
    drv(1, 1'b1, 2'b10, 32'h5000_0200, 1'b0);
    step();
    drv(0, 1'b0, 2'b00, 32'h0, 1'b0);
    drv(1, 1'b0, 2'b00, 32'h0, 1'b0);
    repeat (3) step();
    s_hrdata = 32'h22;
    repeat (3) step();
    chk("t2_m0_rdata", 64'(got[0]), 64'(32'h11));
    chk("t2_m1_rdata", 64'(got[1]), 64'(32'h22));
    // both masters stream back-to-back reads; grants must alternate
    gq.delete();
    repeat (60) begin
      drv(0, 1'b1, 2'b10, {4'h4, 28'($urandom)}, 1'b0);
      drv(1, 1'b1, 2'b10, {4'h5, 28'($urandom)}, 1'b0);
      br($urandom_range(0, 2) != 0, $urandom, 2'b00);
      step();
    end
    chk("t3_enough_grants", 64'(gq.size() >= 4), 64'(1));
    if (gq.size() > 0) chk("t3_first_grant", 64'(gq[0]), 64'(0));
    for (int i = 1; i < gq.size(); i++) chk("t3_alternate", 64'(gq[i]), 64'(!gq[i-1]));
    drv(0, 1'b0, 2'b00, 32'h0, 1'b0);
    drv(1, 1'b0, 2'b00, 32'h0, 1'b0);
    br(1'b1, 32'h0, 2'b00);
    repeat (8) step();
    // hung bridge: watchdog returns a two-cycle ERROR, then M1 is served
    got[1] = '0;
    br(1'b0, 32'h0, 2'b00);
    drv(0, 1'b1, 2'b10, 32'h4000_0444, 1'b0);
    step();
    drv(0, 1'b0, 2'b00, 32'h0, 1'b0);
    repeat (4) step();
    drv(1, 1'b1, 2'b10, 32'h5000_0555, 1'b1);
    m1_hwdata = 32'hCAFE_F00D;
    step();
    drv(1, 1'b0, 2'b00, 32'h0, 1'b0);
    repeat (5) step();
    step();
    chk("t4_err1", 64'(last_m0), 64'(3'b001));
    step();
    chk("t4_err2", 64'(last_m0), 64'(3'b101));
    br(1'b1, 32'h77, 2'b00);
    repeat (3) step();
    chk("t4_m1_addr", 64'(last_addr), 64'(32'h5000_0555));
    chk("t4_m1_rdata", 64'(got[1]), 64'(32'h77));
    // IDLE and BUSY transfers are ignored
    n0 = sel_cnt;
    l0 = low0;
    drv(0, 1'b1, 2'b00, 32'h4000_0888, 1'b0);
    repeat (2) step();
    drv(0, 1'b1, 2'b01, 32'h4000_0888, 1'b0);
    repeat (2) step();
    drv(0, 1'b0, 2'b00, 32'h0, 1'b0);
    step();
    chk("t5_no_pulse", 64'(sel_cnt - n0), 64'(0));
    chk("t5_m0_no_wait", 64'(low0 - l0), 64'(0));
    // reset in the middle of a data phase, then a normal transfer
    br(1'b0, 32'h0, 2'b00);
    drv(0, 1'b1, 2'b10, 32'h4000_0666, 1'b1);
    step();
    drv(0, 1'b0, 2'b00, 32'h0, 1'b0);
    m0_hwdata = 32'h1234_5678;
    repeat (3) step();
    HRESETN = 1'b0;
    mreset();
    step();
    chk("t6_rst_m0", 64'(last_m0), 64'(3'b100));
    chk("t6_rst_bridge", 64'(last_s), 64'(0));
    HRESETN = 1'b1;
    got[1] = '0;
    br(1'b1, 32'h99, 2'b00);
    drv(1, 1'b1, 2'b10, 32'h5000_0777, 1'b0);
    step();
    l0 = low1;
    drv(1, 1'b0, 2'b00, 32'h0, 1'b0);
    repeat (3) step();
    chk("t6_m1_rdata", 64'(got[1]), 64'(32'h99));
    chk("t6_m1_wait", 64'(low1 - l0), 64'(2));
    // random traffic with periods of slow and stalled bridge
    for (int k = 0; k < 400; k++) begin
      drv(0, 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
      drv(1, 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
      m0_hwdata = $urandom;
      m1_hwdata = $urandom;
      br((k % 100) < 70 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 9) == 0, $urandom, 2'($urandom));
      step();
    end
    drv(0, 1'b0, 2'b00, 32'h0, 1'b0);
    drv(1, 1'b0, 2'b00, 32'h0, 1'b0);
    br(1'b1, 32'h0, 2'b00);
    repeat (10) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
